// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: parses host write/read frames from the UART receiver,
// commits buffered writes to the register bank and streams read responses back.
module uart_cmd_ctrl #(
    parameter int g_BUF_DEPTH   = 8,
    parameter int g_TIMEOUT_CYC = 300000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_vld,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    input  logic       i_tx_busy,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    output logic       o_reg_re,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy,
    output logic       o_err
);

    localparam int AW = (g_BUF_DEPTH > 1) ? $clog2(g_BUF_DEPTH) : 1;
    localparam int TW = $clog2(g_TIMEOUT_CYC + 1);

    localparam logic [7:0] HDR_WR = 8'h4B;
    localparam logic [7:0] HDR_RD = 8'hB4;
    localparam logic [7:0] EOF_B  = 8'h0D;
    localparam logic [7:0] ACK_B  = 8'h87;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_W_ADDR   = 4'd1;
    localparam logic [3:0] S_W_LEN    = 4'd2;
    localparam logic [3:0] S_W_DATA   = 4'd3;
    localparam logic [3:0] S_W_EOF    = 4'd4;
    localparam logic [3:0] S_W_COMMIT = 4'd5;
    localparam logic [3:0] S_R_ADDR   = 4'd6;
    localparam logic [3:0] S_R_LEN    = 4'd7;
    localparam logic [3:0] S_R_ACK    = 4'd8;
    localparam logic [3:0] S_R_RD     = 4'd9;
    localparam logic [3:0] S_R_CAP    = 4'd10;
    localparam logic [3:0] S_R_TX     = 4'd11;
    localparam logic [3:0] S_R_END    = 4'd12;
    localparam logic [3:0] S_ERR      = 4'd13;

    logic [3:0]    state;
    logic [7:0]    cnt;
    logic [7:0]    cnt_nxt;
    logic [1:0]    tx_ph;
    logic [TW-1:0] tmo;
    logic [7:0]    addr_q;
    logic [7:0]    len_q;
    logic [7:0]    rd_byte;
    logic [7:0]    buf_mem [g_BUF_DEPTH];
    logic          frame_rx;
    logic          tmo_hit;
    logic          tx_done;
    logic [7:0]    tx_byte;

    always_comb begin
        frame_rx = (state == S_W_ADDR) || (state == S_W_LEN) || (state == S_W_DATA) ||
                   (state == S_W_EOF)  || (state == S_R_ADDR) || (state == S_R_LEN);
        tmo_hit  = frame_rx && !i_rx_vld && (tmo == TW'(g_TIMEOUT_CYC - 1));
        tx_done  = (tx_ph == 2'd2) && !i_tx_busy;
        cnt_nxt  = cnt + 8'd1;
        case (state)
            S_R_ACK: tx_byte = ACK_B;
            S_R_TX:  tx_byte = rd_byte;
            default: tx_byte = EOF_B;
        endcase
    end

    // Frame fields and payload are pure data: no reset needed.
    always_ff @(posedge i_clk) begin
        if (i_rx_vld && frame_rx) begin
            case (state)
                S_W_ADDR, S_R_ADDR: addr_q <= i_rx_data;
                S_W_LEN, S_R_LEN:   len_q  <= i_rx_data;
                S_W_DATA:           buf_mem[cnt[AW-1:0]] <= i_rx_data;
                default: ;
            endcase
        end
        if (state == S_R_CAP) begin
            rd_byte <= i_reg_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            tx_ph       <= 2'd0;
            tmo         <= '0;
            o_tx_data   <= '0;
            o_tx_start  <= 1'b0;
            o_reg_addr  <= '0;
            o_reg_wdata <= '0;
            o_reg_we    <= 1'b0;
            o_reg_re    <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_reg_we   <= 1'b0;
            o_reg_re   <= 1'b0;
            o_err      <= 1'b0;

            if (frame_rx && !i_rx_vld) begin
                tmo <= tmo + TW'(1);
            end else begin
                tmo <= '0;
            end

            // Per-byte transmit handshake: start when idle, see busy rise, then fall.
            if (state == S_R_ACK || state == S_R_TX || state == S_R_END) begin
                case (tx_ph)
                    2'd0: if (!i_tx_busy) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= tx_byte;
                        tx_ph      <= 2'd1;
                    end
                    2'd1: if (i_tx_busy) tx_ph <= 2'd2;
                    default: if (!i_tx_busy) tx_ph <= 2'd0;
                endcase
            end

            if (tmo_hit) begin
                state <= S_ERR;
                o_err <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_rx_vld && i_rx_data == HDR_WR) begin
                            state  <= S_W_ADDR;
                            o_busy <= 1'b1;
                        end else if (i_rx_vld && i_rx_data == HDR_RD) begin
                            state  <= S_R_ADDR;
                            o_busy <= 1'b1;
                        end
                    end
                    S_W_ADDR: if (i_rx_vld) state <= S_W_LEN;
                    S_W_LEN: begin
                        if (i_rx_vld) begin
                            if ({1'b0, i_rx_data} >= 9'(g_BUF_DEPTH)) begin
                                state <= S_ERR;
                                o_err <= 1'b1;
                            end else begin
                                cnt   <= '0;
                                state <= S_W_DATA;
                            end
                        end
                    end
                    S_W_DATA: begin
                        if (i_rx_vld) begin
                            if (cnt == len_q) begin
                                state <= S_W_EOF;
                            end else begin
                                cnt <= cnt_nxt;
                            end
                        end
                    end
                    S_W_EOF: begin
                        if (i_rx_vld) begin
                            if (i_rx_data == EOF_B) begin
                                state       <= S_W_COMMIT;
                                cnt         <= '0;
                                o_reg_we    <= 1'b1;
                                o_reg_addr  <= addr_q;
                                o_reg_wdata <= buf_mem[0];
                            end else begin
                                state <= S_ERR;
                                o_err <= 1'b1;
                            end
                        end
                    end
                    S_W_COMMIT: begin
                        if (cnt == len_q) begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            cnt         <= cnt_nxt;
                            o_reg_we    <= 1'b1;
                            o_reg_addr  <= addr_q + cnt_nxt;
                            o_reg_wdata <= buf_mem[cnt_nxt[AW-1:0]];
                        end
                    end
                    S_R_ADDR: if (i_rx_vld) state <= S_R_LEN;
                    S_R_LEN: begin
                        if (i_rx_vld) begin
                            cnt   <= '0;
                            state <= S_R_ACK;
                        end
                    end
                    S_R_ACK: begin
                        if (tx_done) begin
                            o_reg_re   <= 1'b1;
                            o_reg_addr <= addr_q;
                            state      <= S_R_RD;
                        end
                    end
                    S_R_RD:  state <= S_R_CAP;
                    S_R_CAP: state <= S_R_TX;
                    S_R_TX: begin
                        if (tx_done) begin
                            if (cnt == len_q) begin
                                state <= S_R_END;
                            end else begin
                                cnt        <= cnt_nxt;
                                o_reg_re   <= 1'b1;
                                o_reg_addr <= addr_q + cnt_nxt;
                                state      <= S_R_RD;
                            end
                        end
                    end
                    S_R_END: begin
                        if (tx_done) begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                    S_ERR: begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a register-bank model and a simple transmitter model.
module tb_uart_cmd_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 64;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_vld = 1'b0;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       i_tx_busy = 1'b0;
    logic [7:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic       o_reg_we;
    logic       o_reg_re;
    logic [7:0] i_reg_rdata = 8'h00;
    logic       o_busy;
    logic       o_err;

    uart_cmd_ctrl #(.g_BUF_DEPTH(DEPTH), .g_TIMEOUT_CYC(TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rx_data(i_rx_data), .i_rx_vld(i_rx_vld),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
        .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata),
        .o_reg_we(o_reg_we), .o_reg_re(o_reg_re), .i_reg_rdata(i_reg_rdata),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] bank [256];
    logic [7:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] ra_q[$];
    logic [7:0] tx_q[$];
    int         we_cyc[$];
    int         err_cnt = 0;
    int         err_wide = 0;
    int         err_cyc = 0;
    int         start_bad = 0;
    int         busy_fall_cyc = 0;
    int         tx_left = 0;
    int         last_vld_cyc = 0;
    logic       err_prev = 1'b0;
    logic       busy_prev = 1'b0;

    always @(negedge i_clk) begin
        if (o_reg_we) begin
            wa_q.push_back(o_reg_addr);
            wd_q.push_back(o_reg_wdata);
            we_cyc.push_back(cyc);
            bank[o_reg_addr] = o_reg_wdata;
        end
        if (o_reg_re) begin
            ra_q.push_back(o_reg_addr);
            i_reg_rdata = bank[o_reg_addr];
        end
        if (o_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (o_err && err_prev) err_wide++;
        err_prev = o_err;
        if (busy_prev && !o_busy) busy_fall_cyc = cyc;
        busy_prev = o_busy;
        if (o_tx_start) begin
            if (i_tx_busy) start_bad++;
            tx_q.push_back(o_tx_data);
            i_tx_busy = 1'b1;
            tx_left = 6;
        end else if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) i_tx_busy = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data = b;
        i_rx_vld = 1'b1;
        last_vld_cyc = cyc;
        @(negedge i_clk);
        i_rx_vld = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send(f[i]);
    endtask

    task automatic clear();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        tx_q.delete();
        we_cyc.delete();
        err_cnt = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge i_clk);
        while ((o_busy || i_tx_busy) && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        chk(tag, 32'(n < 2000), 32'd1);
        repeat (3) @(negedge i_clk);
    endtask

    logic [7:0] fr[$];
    logic [7:0] exp_d[8];
    logic [7:0] exp_tx[5];
    int         term_cyc;
    int         n_before;

    initial begin
        for (int i = 0; i < 256; i++) bank[i] = 8'h00;

        repeat (3) @(negedge i_clk);
        chk("rst_we", 32'(o_reg_we), 32'd0);
        chk("rst_re", 32'(o_reg_re), 32'd0);
        chk("rst_busy_err", 32'({o_busy, o_err, o_tx_start}), 32'd0);
        chk("rst_data", 32'({o_tx_data, o_reg_addr, o_reg_wdata}), 32'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Stray byte in IDLE is ignored silently.
        clear();
        send(8'h55);
        chk("stray_err", 32'(err_cnt), 32'd0);
        chk("stray_busy", 32'(o_busy), 32'd0);

        // Init write.
        clear();
        fr = '{8'h4B, 8'h00, 8'h00, 8'h45, 8'h0D};
        send_frame(fr);
        term_cyc = last_vld_cyc;
        wait_idle("init_done");
        chk("init_nwe", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            chk("init_addr", 32'(wa_q[0]), 32'h00);
            chk("init_data", 32'(wd_q[0]), 32'h45);
            chk("init_lat", 32'(we_cyc[0] - term_cyc), 32'd1);
        end
        chk("init_ntx", 32'(tx_q.size()), 32'd0);
        chk("init_err", 32'(err_cnt), 32'd0);

        // Enable write, 8 bytes back to back.
        clear();
        fr = '{8'h4B, 8'h02, 8'h07, 8'hF1, 8'h00, 8'h00, 8'h05,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h0D};
        exp_d = '{8'hF1, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr);
        term_cyc = last_vld_cyc;
        wait_idle("en_done");
        chk("en_nwe", 32'(wa_q.size()), 32'd8);
        if (wa_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("en_addr%0d", i), 32'(wa_q[i]), 32'(8'h02 + i));
                chk($sformatf("en_data%0d", i), 32'(wd_q[i]), 32'(exp_d[i]));
            end
            chk("en_lat", 32'(we_cyc[0] - term_cyc), 32'd1);
            chk("en_gapless", 32'(we_cyc[7] - we_cyc[0]), 32'd7);
            chk("en_busy_fall", 32'(busy_fall_cyc - we_cyc[7]), 32'd1);
        end
        chk("en_err", 32'(err_cnt), 32'd0);

        // Read one byte from address 0 (holds 0x45).
        clear();
        fr = '{8'hB4, 8'h00, 8'h00};
        exp_tx = '{8'h87, 8'h45, 8'h0D, 8'h00, 8'h00};
        send_frame(fr);
        wait_idle("rd_done");
        chk("rd_nre", 32'(ra_q.size()), 32'd1);
        if (ra_q.size() == 1) chk("rd_addr", 32'(ra_q[0]), 32'h00);
        chk("rd_ntx", 32'(tx_q.size()), 32'd3);
        if (tx_q.size() == 3) begin
            for (int i = 0; i < 3; i++) chk($sformatf("rd_tx%0d", i), 32'(tx_q[i]), 32'(exp_tx[i]));
        end
        chk("rd_busy", 32'(o_busy), 32'd0);
        chk("rd_nwe", 32'(wa_q.size()), 32'd0);

        // Wrapping read FE, FF, 00.
        clear();
        bank[8'hFE] = 8'hA1;
        bank[8'hFF] = 8'hB2;
        fr = '{8'hB4, 8'hFE, 8'h02};
        exp_tx = '{8'h87, 8'hA1, 8'hB2, 8'h45, 8'h0D};
        send_frame(fr);
        wait_idle("wrap_done");
        chk("wrap_nre", 32'(ra_q.size()), 32'd3);
        if (ra_q.size() == 3) begin
            chk("wrap_a0", 32'(ra_q[0]), 32'hFE);
            chk("wrap_a1", 32'(ra_q[1]), 32'hFF);
            chk("wrap_a2", 32'(ra_q[2]), 32'h00);
        end
        chk("wrap_ntx", 32'(tx_q.size()), 32'd5);
        if (tx_q.size() == 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("wrap_tx%0d", i), 32'(tx_q[i]), 32'(exp_tx[i]));
        end

        // Bad terminator, then a good frame.
        clear();
        fr = '{8'h4B, 8'h0A, 8'h00, 8'h11, 8'h0C};
        send_frame(fr);
        wait_idle("bad_done");
        chk("bad_nwe", 32'(wa_q.size()), 32'd0);
        chk("bad_err", 32'(err_cnt), 32'd1);
        clear();
        fr = '{8'h4B, 8'h10, 8'h00, 8'h5A, 8'h0D};
        send_frame(fr);
        wait_idle("after_bad_done");
        chk("after_bad_nwe", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) chk("after_bad_w", 32'({wa_q[0], wd_q[0]}), 32'h105A);
        chk("after_bad_err", 32'(err_cnt), 32'd0);

        // LEN equal to buffer depth overflows.
        clear();
        fr = '{8'h4B, 8'h00, 8'h08};
        send_frame(fr);
        wait_idle("ovf_done");
        chk("ovf_err", 32'(err_cnt), 32'd1);
        chk("ovf_nwe", 32'(wa_q.size()), 32'd0);

        // Header then silence.
        clear();
        send(8'h4B);
        term_cyc = last_vld_cyc;
        for (int n = 0; n < TMO + 40 && err_cnt == 0; n++) @(negedge i_clk);
        chk("tmo_err", 32'(err_cnt), 32'd1);
        chk("tmo_lat", 32'(err_cyc - term_cyc), 32'(TMO + 1));
        repeat (3) @(negedge i_clk);
        chk("tmo_busy", 32'(o_busy), 32'd0);

        // Reset mid-commit.
        clear();
        fr = '{8'h4B, 8'h20, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08, 8'h0D};
        send_frame(fr);
        i_rst_n = 1'b0;
        #1;
        chk("mrst_we", 32'(o_reg_we), 32'd0);
        chk("mrst_outs", 32'({o_reg_addr, o_reg_wdata, o_busy, o_err, o_reg_re, o_tx_start}), 32'd0);
        n_before = wa_q.size();
        chk("mrst_partial", 32'(n_before > 0 && n_before < 8), 32'd1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        chk("mrst_no_more", 32'(wa_q.size()), 32'(n_before));
        chk("mrst_busy", 32'(o_busy), 32'd0);

        chk("start_while_busy", 32'(start_bad), 32'd0);
        chk("err_width", 32'(err_wide), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
